// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, state and bundle types for the reorder buffer slice.
// Lane valid is bit 15 of opid in every bundle that carries one.
package reorder_buffer_pkg;
  localparam int RWD   = 2;
  localparam int CWD   = 2;
  localparam int WBWD  = 2;
  localparam int ROBSZ = 16;
  localparam int PRNUM = 64;
  localparam int IW    = $clog2(ROBSZ);
  localparam int PW    = $clog2(PRNUM);
  localparam int AW    = $clog2(RWD + 1);
  localparam int CW    = $clog2(CWD + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WALK  = 2'd1,
    REDIR = 2'd2
  } rob_state_t;

  typedef struct packed {
    logic [15:0]        opid;
    logic [31:0]        ir;
    logic [1:0][PW-1:0] prda;
    logic [31:0]        pc;
  } ren_bundle_t;

  typedef struct packed {
    logic [15:0]        opid;
    logic [4:0]         lrda;
    logic [1:0][PW-1:0] prda;
  } com_bundle_t;

  typedef struct packed {
    logic        rollback;
    logic [15:0] opid;
    logic [7:0]  brid;
    logic [31:0] pc;
  } red_bundle_t;

  // Payload held per entry; pc, done and exc live in separate arrays.
  typedef struct packed {
    logic [15:0]        opid;
    logic [4:0]         lrda;
    logic [1:0][PW-1:0] prda;
  } rob_entry_t;

  function automatic com_bundle_t to_com(input rob_entry_t e);
    com_bundle_t c;
    c.opid = e.opid | 16'h8000;
    c.lrda = e.lrda;
    c.prda = e.prda;
    return c;
  endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// In-order commit selector: the longest done, exception-free run of
// entries starting at head, capped at CWD lanes and at the live count.
module rob_commit_sel
  import reorder_buffer_pkg::*;
(
  input  logic            en,
  input  logic [IW:0]     count,
  input  logic [CWD-1:0]  done,
  input  logic [CWD-1:0]  exc,
  output logic [CWD-1:0]  valid,
  output logic [CW-1:0]   num
);
  logic run_s;

  // Grow the prefix lane by lane; a gap or an exception closes it.
  always_comb begin
    valid = '0;
    num   = '0;
    run_s = en;
    for (int j = 0; j < CWD; j++) begin
      run_s    = run_s && done[j] && !exc[j] && ((IW+1)'(j) < count);
      valid[j] = run_s;
      if (run_s) num = num + CW'(1);
      else       num = num;
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates from rename, retires in order, and on an
// excepting head walks youngest-first back to head before redirecting.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  ren_bundle_t [RWD-1:0]   ren_bundle,
  output logic [RWD-1:0]          rename,
  input  logic                    ren_empty,
  input  logic [WBWD-1:0]         wb_valid,
  input  logic [WBWD-1:0][IW-1:0] wb_robid,
  input  logic [WBWD-1:0]         wb_exc,
  input  logic                    br_valid,
  input  logic [IW-1:0]           br_robid,
  output logic [RWD-1:0][IW-1:0]  robid,
  output com_bundle_t [CWD-1:0]   com_bundle,
  output red_bundle_t             red_bundle
);
  rob_entry_t       entry_r [ROBSZ];
  logic [31:0]      pc_r    [ROBSZ];
  logic [ROBSZ-1:0] done_r, exc_r;
  logic [IW-1:0]    head_r, tail_r, wp_r;
  logic [IW:0]      count_r;
  logic [31:0]      epc_r;
  rob_state_t       state_r;

  logic [CWD-1:0]   win_done_s, win_exc_s, cmt_valid_s;
  logic [CW-1:0]    cmt_num_s;
  logic [AW-1:0]    acc_num_s;
  logic [WBWD-1:0]  wb_live_s;
  logic [IW:0]      free_s, br_count_s;
  logic [IW-1:0]    walk_dist_s;
  logic             exc_start_s, walk_last_s, unused_ren_s;

  assign free_s       = (IW+1)'(ROBSZ) - count_r;
  assign exc_start_s  = (state_r == RUN) && (count_r != '0) && done_r[head_r] && exc_r[head_r];
  assign walk_dist_s  = wp_r - head_r;
  assign walk_last_s  = walk_dist_s < IW'(CWD);
  assign br_count_s   = {1'b0, br_robid - head_r} + (IW+1)'(1) - (IW+1)'(cmt_num_s);
  assign unused_ren_s = ^ren_bundle;

  // Gather done/exc of the oldest CWD entries for the commit selector.
  always_comb begin
    win_done_s = '0;
    win_exc_s  = '0;
    for (int j = 0; j < CWD; j++) begin
      win_done_s[j] = done_r[head_r + IW'(j)];
      win_exc_s[j]  = exc_r[head_r + IW'(j)];
    end
  end

  rob_commit_sel u_commit_sel (
    .en    (state_r == RUN),
    .count (count_r),
    .done  (win_done_s),
    .exc   (win_exc_s),
    .valid (cmt_valid_s),
    .num   (cmt_num_s)
  );

  // Completions only land on live entries, i.e. within [head, tail).
  always_comb begin
    wb_live_s = '0;
    for (int k = 0; k < WBWD; k++) begin
      wb_live_s[k] = wb_valid[k] && ({1'b0, wb_robid[k] - head_r} < count_r);
    end
  end

  // Contiguous-prefix accept; held off on mispredict and on the exception cycle.
  always_comb begin
    logic run;
    rename    = '0;
    acc_num_s = '0;
    run       = (state_r == RUN) && !br_valid && !exc_start_s;
    for (int i = 0; i < RWD; i++) begin
      robid[i]  = tail_r + IW'(i);
      run       = run && ren_bundle[i].opid[15] && ((IW+1)'(i) < free_s);
      rename[i] = run;
      if (run) acc_num_s = acc_num_s + AW'(1);
      else     acc_num_s = acc_num_s;
    end
  end

  // Commit lanes in RUN, youngest-first rollback lanes in WALK, redirect in REDIR.
  always_comb begin
    com_bundle = '0;
    red_bundle = '0;
    case (state_r)
      RUN: begin
        for (int j = 0; j < CWD; j++) begin
          if (cmt_valid_s[j]) com_bundle[j] = to_com(entry_r[head_r + IW'(j)]);
          else                com_bundle[j] = '0;
        end
      end
      WALK: begin
        red_bundle.rollback = 1'b1;
        for (int j = 0; j < CWD; j++) begin
          if (ren_empty && (({1'b0, walk_dist_s} + (IW+1)'(1)) > (IW+1)'(j)))
            com_bundle[j] = to_com(entry_r[wp_r - IW'(j)]);
          else
            com_bundle[j] = '0;
        end
      end
      REDIR: begin
        red_bundle.opid = 16'h8000;
        red_bundle.brid = 8'h00;
        red_bundle.pc   = epc_r;
      end
      default: begin
        com_bundle = '0;
        red_bundle = '0;
      end
    endcase
  end

  // Capture rename payload into freshly allocated entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RWD; i++) begin
      if (rename[i]) begin
        entry_r[tail_r + IW'(i)] <= '{opid: ren_bundle[i].opid,
                                      lrda: ren_bundle[i].ir[11:7],
                                      prda: ren_bundle[i].prda};
        pc_r[tail_r + IW'(i)]    <= ren_bundle[i].pc;
      end
    end
  end

  // Pointers, status bits and the RUN/WALK/REDIR sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      head_r  <= '0;
      tail_r  <= '0;
      wp_r    <= '0;
      count_r <= '0;
      epc_r   <= '0;
      done_r  <= '0;
      exc_r   <= '0;
    end else begin
      for (int k = 0; k < WBWD; k++) begin
        if (wb_live_s[k]) begin
          done_r[wb_robid[k]] <= 1'b1;
          if (wb_exc[k]) exc_r[wb_robid[k]] <= 1'b1;
        end
      end
      for (int i = 0; i < RWD; i++) begin
        if (rename[i]) begin
          done_r[tail_r + IW'(i)] <= 1'b0;
          exc_r[tail_r + IW'(i)]  <= 1'b0;
        end
      end
      case (state_r)
        RUN: begin
          head_r <= head_r + IW'(cmt_num_s);
          if (br_valid) begin
            tail_r  <= br_robid + IW'(1);
            count_r <= br_count_s;
          end else begin
            tail_r  <= tail_r + IW'(acc_num_s);
            count_r <= count_r + (IW+1)'(acc_num_s) - (IW+1)'(cmt_num_s);
          end
          if (exc_start_s) begin
            state_r <= WALK;
            epc_r   <= pc_r[head_r];
            wp_r    <= br_valid ? br_robid : tail_r - IW'(1);
          end
        end
        WALK: begin
          if (ren_empty) begin
            if (walk_last_s) state_r <= REDIR;
            else             wp_r    <= wp_r - IW'(CWD);
          end
        end
        REDIR: begin
          head_r  <= '0;
          tail_r  <= '0;
          count_r <= '0;
          done_r  <= '0;
          exc_r   <= '0;
          state_r <= RUN;
        end
        default: state_r <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all
// checked against a queue-of-entries model of the buffer's rules.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  ren_bundle_t [RWD-1:0]   ren_bundle;
  logic [RWD-1:0]          rename;
  logic                    ren_empty;
  logic [WBWD-1:0]         wb_valid;
  logic [WBWD-1:0][IW-1:0] wb_robid;
  logic [WBWD-1:0]         wb_exc;
  logic                    br_valid;
  logic [IW-1:0]           br_robid;
  logic [RWD-1:0][IW-1:0]  robid;
  com_bundle_t [CWD-1:0]   com_bundle;
  red_bundle_t             red_bundle;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .ren_bundle(ren_bundle), .rename(rename),
    .ren_empty(ren_empty), .wb_valid(wb_valid), .wb_robid(wb_robid),
    .wb_exc(wb_exc), .br_valid(br_valid), .br_robid(br_robid),
    .robid(robid), .com_bundle(com_bundle), .red_bundle(red_bundle)
  );

  typedef struct {
    logic [15:0]   opid;
    logic [4:0]    rd;
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    logic [31:0]   pc;
    bit            done;
    bit            exc;
  } ment_t;

  // Model: q holds live entries oldest first; hd is the index of q[0].
  ment_t       q[$];
  int          hd, ms, wpos;   // ms: 0 running, 1 rolling back, 2 redirecting
  logic [31:0] epc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wb_order[4] = '{3, 1, 0, 2};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_com(input ment_t e);
    com_bundle_t c;
    c.opid    = e.opid | 16'h8000;
    c.lrda    = e.rd;
    c.prda[0] = e.p0;
    c.prda[1] = e.p1;
    return 64'(c);
  endfunction

  task automatic model_reset();
    q.delete();
    hd   = 0;
    ms   = 0;
    wpos = 0;
    epc  = 32'd0;
  endtask

  task automatic idle_inputs();
    ren_bundle = '0;
    ren_empty  = 1'b1;
    wb_valid   = '0;
    wb_robid   = '0;
    wb_exc     = '0;
    br_valid   = 1'b0;
    br_robid   = '0;
  endtask

  task automatic set_lane(input int i, input bit v);
    ren_bundle[i].opid    = {v, 15'($urandom)};
    ren_bundle[i].ir      = $urandom;
    ren_bundle[i].prda[0] = PW'($urandom);
    ren_bundle[i].prda[1] = PW'($urandom);
    ren_bundle[i].pc      = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called just after a negedge with inputs driven: compare, advance model, wait next negedge.
  task automatic step();
    logic [RWD-1:0] e_ren;
    logic [63:0]    e_com [CWD];
    red_bundle_t    e_red;
    ment_t          e;
    int             size, ncmt, p;
    bit             xs, run;
    #1;
    size  = q.size();
    e_ren = '0;
    e_red = '0;
    ncmt  = 0;
    xs    = 1'b0;
    for (int j = 0; j < CWD; j++) e_com[j] = 64'd0;
    if (ms == 0) begin
      xs  = (size > 0) && q[0].done && q[0].exc;
      run = !br_valid && !xs;
      for (int i = 0; i < RWD; i++) begin
        run      = run && ren_bundle[i].opid[15] && (i < ROBSZ - size);
        e_ren[i] = run;
      end
      run = 1'b1;
      for (int j = 0; j < CWD; j++) begin
        if (run && j < size) run = q[j].done && !q[j].exc;
        else                 run = 1'b0;
        if (run) begin
          e_com[j] = exp_com(q[j]);
          ncmt     = j + 1;
        end
      end
    end else if (ms == 1) begin
      e_red.rollback = 1'b1;
      if (ren_empty) begin
        for (int j = 0; j < CWD; j++)
          if (wpos - j >= 0) e_com[j] = exp_com(q[wpos - j]);
      end
    end else begin
      e_red.opid = 16'h8000;
      e_red.pc   = epc;
    end

    check("rename", 64'(rename), 64'(e_ren));
    for (int i = 0; i < RWD; i++)
      check($sformatf("robid%0d", i), 64'(robid[i]), 64'((hd + size + i) % ROBSZ));
    for (int j = 0; j < CWD; j++)
      check($sformatf("com%0d", j), 64'(com_bundle[j]), e_com[j]);
    check("red", 64'(red_bundle), 64'(e_red));

    if (ms == 0) begin
      for (int k = 0; k < WBWD; k++) begin
        if (wb_valid[k]) begin
          p = (int'(wb_robid[k]) - hd + ROBSZ) % ROBSZ;
          if (p < size) begin
            q[p].done = 1'b1;
            if (wb_exc[k]) q[p].exc = 1'b1;
          end
        end
      end
      if (br_valid) begin
        p = (int'(br_robid) - hd + ROBSZ) % ROBSZ;
        while (q.size() > p + 1) void'(q.pop_back());
      end
      for (int j = 0; j < ncmt; j++) void'(q.pop_front());
      hd = (hd + ncmt) % ROBSZ;
      for (int i = 0; i < RWD; i++) begin
        if (e_ren[i]) begin
          e.opid = ren_bundle[i].opid;
          e.rd   = ren_bundle[i].ir[11:7];
          e.p0   = ren_bundle[i].prda[0];
          e.p1   = ren_bundle[i].prda[1];
          e.pc   = ren_bundle[i].pc;
          e.done = 1'b0;
          e.exc  = 1'b0;
          q.push_back(e);
        end
      end
      if (xs) begin
        ms   = 1;
        wpos = q.size() - 1;
        epc  = q[0].pc;
      end
    end else if (ms == 1) begin
      if (ren_empty) begin
        if (wpos < CWD) ms = 2;
        else            wpos = wpos - CWD;
      end
    end else begin
      q.delete();
      hd = 0;
      ms = 0;
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    int size;
    size = q.size();
    for (int i = 0; i < RWD; i++) set_lane(i, $urandom_range(0, 9) < 8);
    ren_empty = $urandom_range(0, 9) < 7;
    for (int k = 0; k < WBWD; k++) begin
      wb_valid[k] = $urandom_range(0, 2) != 0;
      wb_robid[k] = IW'((hd + $urandom_range(0, size + 1)) % ROBSZ);
      wb_exc[k]   = $urandom_range(0, 39) == 0;
    end
    br_valid = 1'b0;
    br_robid = '0;
    if (ms == 0 && size >= 3 && $urandom_range(0, 19) == 0 && !(q[0].done && q[0].exc)) begin
      br_valid = 1'b1;
      br_robid = IW'((hd + $urandom_range(2, size - 1)) % ROBSZ);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_rename", 64'(rename), 64'd0);
    check("reset_com0", 64'(com_bundle[0]), 64'd0);
    check("reset_red", 64'(red_bundle), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fill: two lanes per cycle until full
    for (int c = 0; c < 9; c++) begin
      set_lane(0, 1'b1);
      set_lane(1, 1'b1);
      if (c == 8) begin
        #1;
        check("fill_full", 64'(rename), 64'd0);
      end
      step();
    end

    // Out-of-order completion, in-order commit
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      wb_valid    = 2'b01;
      wb_robid[0] = IW'(wb_order[c]);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Exception at entry 2 with a stalled walk
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1'b1);
      set_lane(1, 1'b1);
      step();
    end
    idle_inputs();
    wb_valid = 2'b11; wb_robid[0] = 4'd0; wb_robid[1] = 4'd1;
    step();
    idle_inputs();
    step();
    idle_inputs();
    wb_valid = 2'b11; wb_robid[0] = 4'd2; wb_exc[0] = 1'b1; wb_robid[1] = 4'd3;
    step();
    idle_inputs();
    step();
    step();
    ren_empty = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_rollback", 64'(red_bundle.rollback), 64'd1);
      step();
    end
    ren_empty = 1'b1;
    repeat (3) step();
    #1;
    check("redir_robid", 64'(robid[0]), 64'd0);

    // Mispredict at entry 4 with 10 live entries, then a late completion to 7
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 1'b1);
      set_lane(1, 1'b1);
      step();
    end
    idle_inputs();
    br_valid = 1'b1; br_robid = 4'd4;
    step();
    idle_inputs();
    #1;
    check("br_tail", 64'(robid[0]), 64'd5);
    wb_valid = 2'b01; wb_robid[0] = 4'd7;
    step();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      wb_valid = 2'b11; wb_robid[0] = IW'(2 * c); wb_robid[1] = IW'(2 * c + 1);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Asynchronous reset in the middle of a walk
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_lane(0, 1'b1);
      set_lane(1, 1'b1);
      step();
    end
    idle_inputs();
    wb_valid = 2'b01; wb_robid[0] = 4'd0; wb_exc[0] = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_rename", 64'(rename), 64'd0);
    check("arst_com0", 64'(com_bundle[0]), 64'd0);
    check("arst_com1", 64'(com_bundle[1]), 64'd0);
    check("arst_red", 64'(red_bundle), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_lane(0, 1'b1);
    #1;
    check("arst_robid", 64'(robid[0]), 64'd0);
    step();

    // Random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
